// File: rtl/cnt_chk_pkg.sv
// Shared definitions for the counter sequence checker: FSM state encoding
// and default widths.
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_TRACK  = 2'd1,
    S_RESYNC = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_ERR_CNT_W  = 8;
  localparam int DEF_WRAP_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments on inc and holds at all-ones instead of wrapping.
// Synchronous active-high reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_checker.sv
// Self-checking stage for a free-running counter: verifies 0 after reset and
// then +1 mod 2^WIDTH, with error pulse, first-error capture and counters.
module cnt_checker
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W,
  parameter int WRAP_CNT_W = DEF_WRAP_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      cnt,
  input  logic                  en,
  output logic                  err,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wraps,
  output logic [WIDTH-1:0]      first_bad,
  output logic [WIDTH-1:0]      first_exp
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_next;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] prev_sample;
  logic             check;
  logic             mismatch;
  logic             wrap_hit;

  // The expectation is always re-based on the actual sample, so a single skip
  // produces exactly one error rather than a cascade.
  always_comb begin
    next_state = state;
    exp_next   = exp_q;
    cmp_val    = exp_q;
    check      = 1'b0;
    case (state)
      S_START: begin
        if (en) begin
          check      = 1'b1;
          cmp_val    = '0;
          exp_next   = cnt + 1'b1;
          next_state = S_TRACK;
        end
      end
      S_TRACK: begin
        if (en) begin
          check    = 1'b1;
          exp_next = cnt + 1'b1;
        end else begin
          next_state = S_RESYNC;
        end
      end
      S_RESYNC: begin
        if (en) begin
          exp_next   = cnt + 1'b1;
          next_state = S_TRACK;
        end
      end
      default: begin
        next_state = S_START;
      end
    endcase
    mismatch = check && (cnt != cmp_val);
    wrap_hit = (state == S_TRACK) && en && !mismatch &&
               (cnt == '0) && (prev_sample == '1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_START;
      exp_q       <= '0;
      prev_sample <= '0;
      err         <= 1'b0;
      err_sticky  <= 1'b0;
      first_bad   <= '0;
      first_exp   <= '0;
    end else begin
      state <= next_state;
      exp_q <= exp_next;
      err   <= mismatch;
      if (en) begin
        prev_sample <= cnt;
      end
      // Only the first error is captured; later ones leave it untouched.
      if (mismatch && !err_sticky) begin
        err_sticky <= 1'b1;
        first_bad  <= cnt;
        first_exp  <= cmp_val;
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch),
    .q     (err_count)
  );

  sat_counter #(.W(WRAP_CNT_W)) u_wraps (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_hit),
    .q     (wraps)
  );

endmodule
